// File: rtl/i2c_reg_ctrl.sv
// Register-access sequencer: turns one host request (device, register, read/write)
// into the full START/WR/RESTART/RD/STOP command sequence for the byte-level i2c_master.
module i2c_reg_ctrl #(
    parameter bit NACK_ABORT = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_i,
    input  logic       rw_i,
    input  logic [6:0] dev_addr_i,
    input  logic [7:0] reg_addr_i,
    input  logic [7:0] wdata_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       nack_o,
    output logic [7:0] rdata_o,
    output logic [2:0] m_cmd_o,
    output logic [7:0] m_din_o,
    output logic       m_wr_o,
    input  logic       m_ready_i,
    input  logic       m_done_tick_i,
    input  logic       m_ack_i,
    input  logic [7:0] m_dout_i
);

    localparam logic [2:0] CMD_START   = 3'b000;
    localparam logic [2:0] CMD_WR      = 3'b001;
    localparam logic [2:0] CMD_RD      = 3'b010;
    localparam logic [2:0] CMD_STOP    = 3'b011;
    localparam logic [2:0] CMD_RESTART = 3'b100;

    localparam logic [2:0] WRITE_STOP_STEP = 3'd4;
    localparam logic [2:0] READ_STOP_STEP  = 3'd6;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LO,
        WAIT_HI,
        ADV
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] step;
    logic       rw_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q;
    logic [7:0] wdata_q;
    logic       ack_q;
    logic [2:0] step_cmd;
    logic [7:0] step_din;
    logic [2:0] stop_step;
    logic       last_step;

    // Command table, indexed by step; derived only from latched request fields so
    // the command presented to the master cannot change while a step is in flight.
    always_comb begin
        step_cmd = CMD_STOP;
        step_din = 8'h00;
        if (rw_q) begin
            case (step)
                3'd0: step_cmd = CMD_START;
                3'd1: begin step_cmd = CMD_WR; step_din = {dev_q, 1'b0}; end
                3'd2: begin step_cmd = CMD_WR; step_din = reg_q; end
                3'd3: step_cmd = CMD_RESTART;
                3'd4: begin step_cmd = CMD_WR; step_din = {dev_q, 1'b1}; end
                3'd5: begin step_cmd = CMD_RD; step_din = 8'h01; end
                default: step_cmd = CMD_STOP;
            endcase
        end else begin
            case (step)
                3'd0: step_cmd = CMD_START;
                3'd1: begin step_cmd = CMD_WR; step_din = {dev_q, 1'b0}; end
                3'd2: begin step_cmd = CMD_WR; step_din = reg_q; end
                3'd3: begin step_cmd = CMD_WR; step_din = wdata_q; end
                default: step_cmd = CMD_STOP;
            endcase
        end
    end

    assign stop_step = rw_q ? READ_STOP_STEP : WRITE_STOP_STEP;
    assign last_step = (step == stop_step);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_i) state_next = ISSUE;
            ISSUE:   if (m_ready_i) state_next = WAIT_LO;
            WAIT_LO: if (!m_ready_i) state_next = WAIT_HI;
            WAIT_HI: if (m_ready_i) state_next = ADV;
            ADV:     state_next = last_step ? IDLE : ISSUE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are decoded from state so reset clears them without a clock.
    always_comb begin
        busy_o  = (state != IDLE) && !((state == ADV) && last_step);
        done_o  = (state == ADV) && last_step;
        m_wr_o  = (state == ISSUE) && m_ready_i;
        m_cmd_o = step_cmd;
        m_din_o = step_din;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            step    <= 3'd0;
            rw_q    <= 1'b0;
            dev_q   <= 7'h00;
            reg_q   <= 8'h00;
            wdata_q <= 8'h00;
            ack_q   <= 1'b0;
            nack_o  <= 1'b0;
            rdata_o <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i) begin
                        rw_q    <= rw_i;
                        dev_q   <= dev_addr_i;
                        reg_q   <= reg_addr_i;
                        wdata_q <= wdata_i;
                        step    <= 3'd0;
                        ack_q   <= 1'b0;
                        nack_o  <= 1'b0;
                    end
                end
                WAIT_HI: begin
                    // The ACK bit of the RD step is our own NACK, so it is not captured.
                    if (m_done_tick_i) begin
                        if (step_cmd == CMD_WR) begin
                            ack_q <= m_ack_i;
                        end else if (step_cmd == CMD_RD) begin
                            rdata_o <= m_dout_i;
                        end
                    end
                end
                ADV: begin
                    ack_q <= 1'b0;
                    if (last_step) begin
                        step <= 3'd0;
                    end else if ((step_cmd == CMD_WR) && ack_q) begin
                        nack_o <= 1'b1;
                        step   <= NACK_ABORT ? stop_step : step + 3'd1;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed bench for i2c_reg_ctrl: a small i2c_master/slave model logs every command
// and answers with configurable ACK/NACK and read data; two instances cover both NACK policies.
module tb_i2c_reg_ctrl;

    localparam logic [2:0] CMD_START   = 3'b000;
    localparam logic [2:0] CMD_WR      = 3'b001;
    localparam logic [2:0] CMD_RD      = 3'b010;
    localparam logic [2:0] CMD_STOP    = 3'b011;
    localparam logic [2:0] CMD_RESTART = 3'b100;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       req_i;
    logic       rw_i;
    logic [6:0] dev_addr_i;
    logic [7:0] reg_addr_i;
    logic [7:0] wdata_i;
    logic       m_ready_i;
    logic       m_done_tick_i;
    logic       m_ack_i;
    logic [7:0] m_dout_i;
    logic       sel;

    logic       req_a, busy_a, done_a, nack_a, m_wr_a;
    logic [7:0] rdata_a, m_din_a;
    logic [2:0] m_cmd_a;
    logic       req_b, busy_b, done_b, nack_b, m_wr_b;
    logic [7:0] rdata_b, m_din_b;
    logic [2:0] m_cmd_b;

    logic       busy, done, nack, m_wr;
    logic [7:0] rdata, m_din;
    logic [2:0] m_cmd;

    int         checks = 0;
    int         errors = 0;
    logic [10:0] log_q[$];
    logic [10:0] exp_q[$];
    logic [2:0] wr_cnt;
    logic [7:0] nack_mask;
    logic [7:0] slave_rdata;
    logic [2:0] bfm_cmd;

    logic       busy_done, nack_done, found;
    logic [7:0] rdata_done;
    int         ndone;

    always #5 clk_i = ~clk_i;

    assign req_a = req_i & ~sel;
    assign req_b = req_i & sel;
    assign busy  = sel ? busy_b  : busy_a;
    assign done  = sel ? done_b  : done_a;
    assign nack  = sel ? nack_b  : nack_a;
    assign m_wr  = sel ? m_wr_b  : m_wr_a;
    assign rdata = sel ? rdata_b : rdata_a;
    assign m_din = sel ? m_din_b : m_din_a;
    assign m_cmd = sel ? m_cmd_b : m_cmd_a;

    i2c_reg_ctrl #(.NACK_ABORT(1'b1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_a), .rw_i(rw_i),
        .dev_addr_i(dev_addr_i), .reg_addr_i(reg_addr_i), .wdata_i(wdata_i),
        .busy_o(busy_a), .done_o(done_a), .nack_o(nack_a), .rdata_o(rdata_a),
        .m_cmd_o(m_cmd_a), .m_din_o(m_din_a), .m_wr_o(m_wr_a),
        .m_ready_i(m_ready_i), .m_done_tick_i(m_done_tick_i),
        .m_ack_i(m_ack_i), .m_dout_i(m_dout_i)
    );

    i2c_reg_ctrl #(.NACK_ABORT(1'b0)) dut_no_abort (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_b), .rw_i(rw_i),
        .dev_addr_i(dev_addr_i), .reg_addr_i(reg_addr_i), .wdata_i(wdata_i),
        .busy_o(busy_b), .done_o(done_b), .nack_o(nack_b), .rdata_o(rdata_b),
        .m_cmd_o(m_cmd_b), .m_din_o(m_din_b), .m_wr_o(m_wr_b),
        .m_ready_i(m_ready_i), .m_done_tick_i(m_done_tick_i),
        .m_ack_i(m_ack_i), .m_dout_i(m_dout_i)
    );

    task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task checkLog(input string tag);
        checkOutput({tag, "_len"}, log_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            checkOutput($sformatf("%s_cmd%0d", tag, i),
                        (i < log_q.size()) ? {21'd0, log_q[i]} : 32'hFFFF_FFFF,
                        {21'd0, exp_q[i]});
        end
    endtask

    // Master + slave model: one accepted command drops ready, returns a byte tick, then idles.
    initial begin
        m_ready_i     = 1'b1;
        m_done_tick_i = 1'b0;
        m_ack_i       = 1'b0;
        m_dout_i      = 8'h00;
        forever begin
            @(negedge clk_i);
            if (m_wr === 1'b1) begin
                bfm_cmd = m_cmd;
                log_q.push_back({m_cmd, m_din});
                @(posedge clk_i);
                #1 m_ready_i = 1'b0;
                @(posedge clk_i);
                #1;
                if (bfm_cmd == CMD_WR) begin
                    m_done_tick_i = 1'b1;
                    m_ack_i       = nack_mask[wr_cnt];
                    wr_cnt        = wr_cnt + 3'd1;
                end else if (bfm_cmd == CMD_RD) begin
                    m_done_tick_i = 1'b1;
                    m_ack_i       = 1'b1;
                    m_dout_i      = slave_rdata;
                end
                @(posedge clk_i);
                #1;
                m_done_tick_i = 1'b0;
                m_ack_i       = 1'b0;
                m_ready_i     = 1'b1;
            end
        end
    end

    task applyStimulus(input logic r, input logic [6:0] d, input logic [7:0] ra,
                       input logic [7:0] wd, input logic poke);
        log_q.delete();
        wr_cnt     = 3'd0;
        ndone      = 0;
        busy_done  = 1'b1;
        nack_done  = 1'b0;
        rdata_done = 8'h00;
        found      = 1'b0;
        @(posedge clk_i);
        #1;
        req_i = 1'b1; rw_i = r; dev_addr_i = d; reg_addr_i = ra; wdata_i = wd;
        @(posedge clk_i);
        #1 req_i = 1'b0;
        @(negedge clk_i);
        checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
        if (poke) begin
            repeat (3) @(posedge clk_i);
            #1;
            req_i = 1'b1; rw_i = ~r; wdata_i = 8'hFF;
            @(posedge clk_i);
            #1 req_i = 1'b0;
        end
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk_i);
            if (done === 1'b1) begin
                found      = 1'b1;
                ndone++;
                busy_done  = busy;
                nack_done  = nack;
                rdata_done = rdata;
            end
        end
        checkOutput("done_seen", {31'd0, found}, 32'd1);
        if (poke) req_i = 1'b1;
        @(posedge clk_i);
        #1 req_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (done === 1'b1) ndone++;
        end
    endtask

    initial begin
        sel = 1'b0; req_i = 1'b0; rw_i = 1'b0;
        dev_addr_i = 7'h00; reg_addr_i = 8'h00; wdata_i = 8'h00;
        nack_mask = 8'h00; slave_rdata = 8'h00; wr_cnt = 3'd0;
        rst_ni = 1'b0;
        #12;
        checkOutput("rst_busy",  {31'd0, busy}, 32'd0);
        checkOutput("rst_done",  {31'd0, done}, 32'd0);
        checkOutput("rst_nack",  {31'd0, nack}, 32'd0);
        checkOutput("rst_m_wr",  {31'd0, m_wr}, 32'd0);
        checkOutput("rst_rdata", {24'd0, rdata}, 32'h00);
        checkOutput("rst_m_din", {24'd0, m_din}, 32'h00);
        checkOutput("rst_m_cmd", {29'd0, m_cmd}, 32'd0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        $display("[TB] register write, all ACK");
        applyStimulus(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0);
        exp_q = '{{CMD_START, 8'h00}, {CMD_WR, 8'hA0}, {CMD_WR, 8'h10},
                  {CMD_WR, 8'hA5}, {CMD_STOP, 8'h00}};
        checkLog("wr");
        checkOutput("wr_ndone", ndone, 1);
        checkOutput("wr_busy_at_done", {31'd0, busy_done}, 32'd0);
        checkOutput("wr_nack", {31'd0, nack_done}, 32'd0);
        checkOutput("wr_rdata_kept", {24'd0, rdata_done}, 32'h00);

        $display("[TB] register read returning 0x3C");
        slave_rdata = 8'h3C;
        applyStimulus(1'b1, 7'h50, 8'h20, 8'h00, 1'b0);
        exp_q = '{{CMD_START, 8'h00}, {CMD_WR, 8'hA0}, {CMD_WR, 8'h20},
                  {CMD_RESTART, 8'h00}, {CMD_WR, 8'hA1}, {CMD_RD, 8'h01},
                  {CMD_STOP, 8'h00}};
        checkLog("rd");
        checkOutput("rd_ndone", ndone, 1);
        checkOutput("rd_rdata", {24'd0, rdata_done}, 32'h3C);
        checkOutput("rd_nack", {31'd0, nack_done}, 32'd0);

        $display("[TB] absent slave, abort on address NACK");
        nack_mask   = 8'b0000_0001;
        slave_rdata = 8'h55;
        applyStimulus(1'b1, 7'h50, 8'h20, 8'h00, 1'b0);
        exp_q = '{{CMD_START, 8'h00}, {CMD_WR, 8'hA0}, {CMD_STOP, 8'h00}};
        checkLog("abort");
        checkOutput("abort_ndone", ndone, 1);
        checkOutput("abort_nack", {31'd0, nack_done}, 32'd1);
        checkOutput("abort_rdata_kept", {24'd0, rdata_done}, 32'h3C);

        $display("[TB] requests while busy and in the done cycle");
        nack_mask = 8'h00;
        applyStimulus(1'b0, 7'h50, 8'h10, 8'hA5, 1'b1);
        exp_q = '{{CMD_START, 8'h00}, {CMD_WR, 8'hA0}, {CMD_WR, 8'h10},
                  {CMD_WR, 8'hA5}, {CMD_STOP, 8'h00}};
        checkLog("poke");
        checkOutput("poke_ndone", ndone, 1);
        checkOutput("poke_nack", {31'd0, nack_done}, 32'd0);
        checkOutput("poke_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("poke_no_extra_cmd", log_q.size(), 5);

        $display("[TB] reset during WR reg step");
        log_q.delete();
        wr_cnt = 3'd0;
        @(posedge clk_i);
        #1;
        req_i = 1'b1; rw_i = 1'b0; dev_addr_i = 7'h50; reg_addr_i = 8'h11; wdata_i = 8'h77;
        @(posedge clk_i);
        #1 req_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk_i);
            if (log_q.size() >= 3) found = 1'b1;
        end
        checkOutput("rst_mid_reached", {31'd0, found}, 32'd1);
        #3 rst_ni = 1'b0;
        #1;
        checkOutput("rst_mid_busy",  {31'd0, busy}, 32'd0);
        checkOutput("rst_mid_m_wr",  {31'd0, m_wr}, 32'd0);
        checkOutput("rst_mid_m_cmd", {29'd0, m_cmd}, 32'd0);
        checkOutput("rst_mid_m_din", {24'd0, m_din}, 32'h00);
        checkOutput("rst_mid_nack",  {31'd0, nack}, 32'd0);
        checkOutput("rst_mid_rdata", {24'd0, rdata}, 32'h00);
        repeat (6) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        applyStimulus(1'b0, 7'h50, 8'h33, 8'hC3, 1'b0);
        exp_q = '{{CMD_START, 8'h00}, {CMD_WR, 8'hA0}, {CMD_WR, 8'h33},
                  {CMD_WR, 8'hC3}, {CMD_STOP, 8'h00}};
        checkLog("post_rst");
        checkOutput("post_rst_ndone", ndone, 1);
        checkOutput("post_rst_nack", {31'd0, nack_done}, 32'd0);

        $display("[TB] no-abort instance, data byte NACK");
        sel       = 1'b1;
        nack_mask = 8'b0000_0100;
        applyStimulus(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0);
        exp_q = '{{CMD_START, 8'h00}, {CMD_WR, 8'hA0}, {CMD_WR, 8'h10},
                  {CMD_WR, 8'hA5}, {CMD_STOP, 8'h00}};
        checkLog("noabort");
        checkOutput("noabort_ndone", ndone, 1);
        checkOutput("noabort_nack", {31'd0, nack_done}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
